// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit.
//   - FSM state enum
//   - bus read_type / write_type encodings
//   - RISC-V load/store funct3 constants
//   - decode_funct3(): maps funct3/is_store to bus types, access size, illegal flag
//   - is_misaligned(): alignment check for an access size and the low address bits
package load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } lsu_state_t;

  // read_type: bit2 = sign-extend request, bits[1:0] = size
  localparam logic [2:0] READ_NONE   = 3'b000;
  localparam logic [2:0] READ_BYTE   = 3'b001;
  localparam logic [2:0] READ_HALF   = 3'b010;
  localparam logic [2:0] READ_WORD   = 3'b011;
  localparam logic [2:0] READ_SIGNED = 3'b100;

  localparam logic [1:0] WRITE_NONE = 2'b00;
  localparam logic [1:0] WRITE_BYTE = 2'b01;
  localparam logic [1:0] WRITE_HALF = 2'b10;
  localparam logic [1:0] WRITE_WORD = 2'b11;

  // funct3 codes (loads use all five, stores only the first three)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2
  } access_size_t;

  typedef struct packed {
    logic [2:0]   read_type;
    logic [1:0]   write_type;
    access_size_t size;
    logic         illegal;
  } bus_type_t;

  function automatic bus_type_t decode_funct3(input logic [2:0] funct3,
                                              input logic       is_store);
    bus_type_t t;
    t.read_type  = READ_NONE;
    t.write_type = WRITE_NONE;
    t.size       = SIZE_BYTE;
    t.illegal    = 1'b0;
    if (is_store) begin
      case (funct3)
        F3_B:    begin t.write_type = WRITE_BYTE; t.size = SIZE_BYTE; end
        F3_H:    begin t.write_type = WRITE_HALF; t.size = SIZE_HALF; end
        F3_W:    begin t.write_type = WRITE_WORD; t.size = SIZE_WORD; end
        default: t.illegal = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B:    begin t.read_type = READ_SIGNED | READ_BYTE; t.size = SIZE_BYTE; end
        F3_H:    begin t.read_type = READ_SIGNED | READ_HALF; t.size = SIZE_HALF; end
        F3_W:    begin t.read_type = READ_SIGNED | READ_WORD; t.size = SIZE_WORD; end
        F3_BU:   begin t.read_type = READ_BYTE;               t.size = SIZE_BYTE; end
        F3_HU:   begin t.read_type = READ_HALF;               t.size = SIZE_HALF; end
        default: t.illegal = 1'b1;
      endcase
    end
    return t;
  endfunction

  function automatic logic is_misaligned(input access_size_t size,
                                         input logic [1:0]   addr_lo);
    logic bad;
    case (size)
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one CPU load/store request at a time and runs it
// on a simple memory/I-O bus.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   req_valid/req_ready        CPU request handshake
//   req_is_store, req_funct3,
//   req_addr, req_wdata        request fields, captured on accept
//   resp_valid                 one-cycle completion pulse
//   resp_rdata, resp_fault     response payload, zero unless resp_valid
//   enable, read_type,
//   write_type, address,
//   data_out                   bus request, zero outside ISSUE/WAIT
//   data_in, data_in_ready     bus read data and its valid
//   busy                       bus busy
//
// Handshake: a request transfers on a cycle where req_valid && req_ready
// (req_ready is high only in IDLE). The response has no backpressure:
// resp_valid is a single-cycle pulse that the CPU must take.
//
// The internal signal 'state' (lsu_state_t) carries the FSM state for
// observation by checkers.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int AddressBitWidth = 32,
  parameter int DataBitWidth    = 32,
  parameter int TimeoutCycles   = 1023
) (
  input  logic                       clk,
  input  logic                       rst_n,
  // CPU request
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_is_store,
  input  logic [2:0]                 req_funct3,
  input  logic [AddressBitWidth-1:0] req_addr,
  input  logic [DataBitWidth-1:0]    req_wdata,
  // CPU response
  output logic                       resp_valid,
  output logic [DataBitWidth-1:0]    resp_rdata,
  output logic                       resp_fault,
  // memory / I-O bus
  output logic                       enable,
  output logic [2:0]                 read_type,
  output logic [1:0]                 write_type,
  output logic [AddressBitWidth-1:0] address,
  output logic [DataBitWidth-1:0]    data_out,
  input  logic [DataBitWidth-1:0]    data_in,
  input  logic                       data_in_ready,
  input  logic                       busy
);

  localparam int CntW = $clog2(TimeoutCycles + 1);

  lsu_state_t state;
  lsu_state_t state_next;

  // registered request
  logic                       is_store_q;
  logic [2:0]                 read_type_q;
  logic [1:0]                 write_type_q;
  logic [AddressBitWidth-1:0] addr_q;
  logic [DataBitWidth-1:0]    wdata_q;

  // registered response payload
  logic [DataBitWidth-1:0]    rdata_q;
  logic                       fault_q;

  logic [CntW-1:0]            wait_cnt;

  bus_type_t decoded;
  logic      accept;
  logic      req_bad;
  logic      wait_done;
  logic      timeout_hit;

  assign decoded = decode_funct3(req_funct3, req_is_store);
  assign accept  = req_valid && (state == ST_IDLE);
  // Bad requests never reach the bus; they go straight to a fault response.
  assign req_bad = decoded.illegal || is_misaligned(decoded.size, req_addr[1:0]);

  // Stores only need the bus to be free; loads also need the read data.
  assign wait_done   = is_store_q ? !busy : (!busy && data_in_ready);
  // wait_cnt counts the WAIT cycles already spent, so the cycle with
  // count TimeoutCycles-1 is the last one allowed.
  assign timeout_hit = (wait_cnt >= CntW'(TimeoutCycles - 1));

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (accept) state_next = req_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE: state_next = ST_WAIT;
      ST_WAIT:  if (wait_done || timeout_hit) state_next = ST_RESP;
      ST_RESP:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // ---------------- request / response / counter registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      is_store_q   <= 1'b0;
      read_type_q  <= READ_NONE;
      write_type_q <= WRITE_NONE;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      fault_q      <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (accept) begin
        is_store_q   <= req_is_store;
        read_type_q  <= decoded.read_type;
        write_type_q <= decoded.write_type;
        addr_q       <= req_addr;
        wdata_q      <= req_is_store ? req_wdata : '0;
        rdata_q      <= '0;
        fault_q      <= req_bad;
      end
      if (state == ST_ISSUE) begin
        wait_cnt <= '0;
      end
      if (state == ST_WAIT) begin
        if (wait_done) begin
          rdata_q <= is_store_q ? '0 : data_in;
          fault_q <= 1'b0;
        end else if (timeout_hit) begin
          rdata_q <= '0;
          fault_q <= 1'b1;
        end
        // saturate rather than wrap
        if (wait_cnt < CntW'(TimeoutCycles)) wait_cnt <= wait_cnt + CntW'(1);
      end
    end
  end

  // ---------------- outputs ----------------
  // All bus and response outputs are gated copies of registers, so they
  // are zero outside the states that own them.
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_fault = 1'b0;
    enable     = 1'b0;
    read_type  = READ_NONE;
    write_type = WRITE_NONE;
    address    = '0;
    data_out   = '0;
    case (state)
      ST_IDLE: req_ready = 1'b1;
      ST_ISSUE, ST_WAIT: begin
        enable     = 1'b1;
        read_type  = read_type_q;
        write_type = write_type_q;
        address    = addr_q;
        data_out   = wdata_q;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_fault = fault_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit (TimeoutCycles = 8).
// Each request pushes its expected {fault, rdata} onto exp_q; the entry is
// popped and compared when resp_valid appears. Latency, enable duration and
// bus stability are checked per request.
module tb_load_store_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_is_store;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic [DW-1:0] resp_rdata;
  logic          resp_fault;
  logic          enable;
  logic [2:0]    read_type;
  logic [1:0]    write_type;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;
  logic [DW-1:0] data_in;
  logic          data_in_ready;
  logic          busy;

  int checks = 0;
  int errors = 0;
  logic [DW:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  load_store_unit #(
    .AddressBitWidth(AW),
    .DataBitWidth   (DW),
    .TimeoutCycles  (TO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_fault   (resp_fault),
    .enable       (enable),
    .read_type    (read_type),
    .write_type   (write_type),
    .address      (address),
    .data_out     (data_out),
    .data_in      (data_in),
    .data_in_ready(data_in_ready),
    .busy         (busy)
  );

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver: one full request ----------------
  // exp_lat counts negedges from the accept edge to the resp_valid sample.
  // busy_wait = number of WAIT cycles with busy held high (data_in_ready
  // stays high throughout, so a load must still wait on busy).
  task automatic run_req(input string tag, input logic st, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] din, input int busy_wait,
                         input logic [2:0] exp_rt, input logic [1:0] exp_wt,
                         input int exp_lat, input logic exp_fault);
    int cyc;
    int en_cycles;
    int bus_bad;
    int exp_en;
    logic [31:0] exp_dout;
    logic [DW:0] exp_resp;
    exp_resp = {exp_fault, (exp_fault || st) ? 32'h0 : din};
    exp_q.push_back(exp_resp);
    exp_dout = st ? wdata : 32'h0;
    exp_en   = (exp_lat == 1) ? 0 : exp_lat - 1;

    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = st;
    req_funct3   = f3;
    req_addr     = addr;
    req_wdata    = wdata;
    data_in      = din;
    data_in_ready = 1'b1;
    busy         = (busy_wait > 0);
    check({tag, "_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    // scramble request inputs so only the captured copy can drive the bus
    req_valid = 1'b0;
    req_addr  = ~addr;
    req_wdata = ~wdata;

    cyc = 1; en_cycles = 0; bus_bad = 0;
    while (!resp_valid && cyc < 40) begin
      if (enable) begin
        en_cycles++;
        if (address !== addr || data_out !== exp_dout ||
            read_type !== exp_rt || write_type !== exp_wt) bus_bad++;
      end else if ({read_type, write_type, address, data_out} !== '0) begin
        bus_bad++;
      end
      busy = (cyc < 2) ? (busy_wait > 0) : (cyc - 2 < busy_wait);
      @(negedge clk);
      cyc++;
    end
    busy = 1'b0;
    check({tag, "_resp_seen"}, 64'(resp_valid), 64'd1);
    check({tag, "_latency"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_enable_cycles"}, 64'(en_cycles), 64'(exp_en));
    check({tag, "_bus_stable"}, 64'(bus_bad), 64'd0);
    if (resp_valid) begin
      if (exp_q.size() == 0) check({tag, "_queue_empty"}, 64'd1, 64'd0);
      else check({tag, "_resp"}, 64'({resp_fault, resp_rdata}), 64'(exp_q.pop_front()));
    end else if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
    end
    @(negedge clk);
    check({tag, "_after"}, 64'({resp_valid, resp_fault, resp_rdata, enable, req_ready}),
          64'({1'b0, 1'b0, 32'h0, 1'b0, 1'b1}));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    int resp_count;
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0;
    req_addr = '0; req_wdata = '0;
    data_in = '0; data_in_ready = 1'b0; busy = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          64'({req_ready, resp_valid, resp_rdata, resp_fault, enable, read_type, write_type}),
          64'({1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 3'b000, 2'b00}));
    check("reset_bus", 64'({address, data_out}), 64'd0);
    rst_n = 1'b1;

    //        tag        st    f3      addr          wdata         din           bw   rt      wt     lat fault
    run_req("lw_100",   1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0,  3'b111, 2'b00, 3,  1'b0);
    run_req("sb_103",   1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5, 32'h1234_5678, 5,  3'b000, 2'b01, 8,  1'b0);
    run_req("lh_101",   1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h5555_5555, 0,  3'b000, 2'b00, 1,  1'b1);
    run_req("lbu_top",  1'b0, 3'b100, 32'hFFFF_FFFE, 32'h0,        32'h0000_0041, 0,  3'b001, 2'b00, 3,  1'b0);
    run_req("lw_tmo",   1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'hCAFE_F00D, 100, 3'b111, 2'b00, 2 + TO, 1'b1);
    run_req("ld_ill",   1'b0, 3'b011, 32'h0000_0000, 32'h0,        32'h1111_1111, 0,  3'b000, 2'b00, 1,  1'b1);
    run_req("sw_mis",   1'b1, 3'b010, 32'h0000_0102, 32'hAAAA_AAAA, 32'h0,        0,  3'b000, 2'b00, 1,  1'b1);
    run_req("st_ill",   1'b1, 3'b100, 32'h0000_0100, 32'h0000_0001, 32'h0,        0,  3'b000, 2'b00, 1,  1'b1);
    run_req("sh_202",   1'b1, 3'b001, 32'h0000_0202, 32'h0000_BEEF, 32'h7777_7777, 2,  3'b000, 2'b10, 5,  1'b0);
    run_req("lh_006",   1'b0, 3'b001, 32'h0000_0006, 32'h0,        32'hFFFF_8001, 0,  3'b110, 2'b00, 3,  1'b0);
    run_req("lb_007",   1'b0, 3'b000, 32'h0000_0007, 32'h0,        32'h0000_0080, 1,  3'b101, 2'b00, 4,  1'b0);
    run_req("lhu_00a",  1'b0, 3'b101, 32'h0000_000A, 32'h0,        32'h0000_ABCD, 0,  3'b010, 2'b00, 3,  1'b0);
    run_req("sw_ok",    1'b1, 3'b010, 32'h0000_0ABC, 32'h0BAD_F00D, 32'h0,        0,  3'b000, 2'b11, 3,  1'b0);

    // reset while waiting on the bus: enable drops, no response follows
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0000_0300; busy = 1'b1; data_in_ready = 1'b0;
    check("rst_mid_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_wait", 64'(enable), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_outputs", 64'({enable, req_ready, resp_valid}), 64'({1'b0, 1'b1, 1'b0}));
    rst_n = 1'b1;
    busy = 1'b0; data_in_ready = 1'b1;
    resp_count = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (resp_valid || enable) resp_count++;
    end
    check("rst_mid_no_resp", 64'(resp_count), 64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
